change_dispenser: RTL and testbench

Downstream of the vending machine core. Takes the change amount the core produces, plus the per-denomination coin availability vector. Ejects coins one at a time with a greedy largest-coin-first algorithm, driving one-hot eject strobes to the coin mechanism. Reports completion and any shortfall the available coins could not cover.

---
 rtl/change_dispenser_pkg.sv | 25 ++
 rtl/change_dispenser_if.sv | 27 ++
 rtl/change_dispenser_coin_picker.sv | 36 +++
 rtl/change_dispenser.sv | 113 +++++++++++
 tb/tb_change_dispenser.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared coin mapping, coin values and FSM encoding for the change dispenser.
// The coin bit order matches the vending core's coin_signal.
package change_dispenser_pkg;

    localparam int COIN_N      = 5;
    localparam int NICKEL_BIT  = 0;
    localparam int DIME_BIT    = 1;
    localparam int QUARTER_BIT = 2;
    localparam int HALF_BIT    = 3;
    localparam int DOLLAR_BIT  = 4;

    // Indexed by coin bit; values in cents.
    localparam int unsigned COIN_VALUE [COIN_N] = '{5, 10, 25, 50, 100};

    typedef logic [COIN_N-1:0] coin_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Request/response bundle between the vending core and the change dispenser.
interface change_dispenser_if
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 7,
    parameter int CNT_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    coin_vec_t        coin_avail;
    coin_vec_t        eject;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic [CNT_W-1:0] coins_out;

    modport master (
        output req_valid, req_amount, coin_avail,
        input  req_ready, eject, busy, done, shortfall, coins_out
    );

    modport slave (
        input  req_valid, req_amount, coin_avail,
        output req_ready, eject, busy, done, shortfall, coins_out
    );
endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Greedy coin choice: highest-value available coin that still fits the remainder.
module change_dispenser_coin_picker
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remaining,
    input  coin_vec_t        coin_avail,
    output logic             found,
    output coin_vec_t        coin,
    output logic [AMT_W-1:0] value
);

    coin_vec_t fits;

    // Compare at 32 bits so a coin wider than the amount field simply never fits.
    for (genvar gi = 0; gi < COIN_N; gi++) begin : g_fit
        assign fits[gi] = coin_avail[gi] && (COIN_VALUE[gi] <= 32'(remaining));
    end

    always_comb begin
        found = 1'b0;
        coin  = '0;
        value = '0;
        // Ascending scan; the last match (largest coin) wins.
        for (int i = 0; i < COIN_N; i++) begin
            if (fits[i]) begin
                found   = 1'b1;
                coin    = '0;
                coin[i] = 1'b1;
                value   = AMT_W'(COIN_VALUE[i]);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change amount and ejects coins one per pulse,
// largest first, then reports the undispensed shortfall.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W     = 7,
    parameter int EJECT_GAP = 2,
    parameter int CNT_W     = 5
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);

    localparam int GAP_W = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;

    state_t           state_reg;
    logic [AMT_W-1:0] remaining_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    coin_vec_t        eject_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [AMT_W-1:0] shortfall_reg;
    logic [CNT_W-1:0] coins_reg;

    logic             pick_found;
    coin_vec_t        pick_coin;
    logic [AMT_W-1:0] pick_value;

    // Availability is read live so a coin running out mid-request affects later picks only.
    change_dispenser_coin_picker #(.AMT_W(AMT_W)) u_picker (
        .remaining  (remaining_reg),
        .coin_avail (bus.coin_avail),
        .found      (pick_found),
        .coin       (pick_coin),
        .value      (pick_value)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            gap_cnt_reg   <= '0;
            eject_reg     <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            shortfall_reg <= '0;
            coins_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        remaining_reg <= bus.req_amount;
                        coins_reg     <= '0;
                        ready_reg     <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    // A zero remainder never finds a coin, so it ends with shortfall 0.
                    if (pick_found) begin
                        remaining_reg <= remaining_reg - pick_value;
                        eject_reg     <= pick_coin;
                        if (coins_reg != '1) begin
                            coins_reg <= coins_reg + 1'b1;
                        end
                        state_reg     <= ST_EJECT;
                    end else begin
                        shortfall_reg <= remaining_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_EJECT: begin
                    eject_reg <= '0;
                    if (EJECT_GAP > 0) begin
                        gap_cnt_reg <= GAP_W'(EJECT_GAP - 1);
                        state_reg   <= ST_GAP;
                    end else begin
                        state_reg <= ST_SELECT;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= ST_SELECT;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.eject     = eject_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.shortfall = shortfall_reg;
    assign bus.coins_out = coins_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: one instance with a 2-cycle eject gap,
// one with no gap; ejects and completions are checked for value and cycle offset.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int AMT_W = 7;
    localparam int CNT_W = 5;

    typedef struct {
        bit               is_done;
        logic [4:0]       ej;
        logic [AMT_W-1:0] sf;
        logic [CNT_W-1:0] cn;
        int               off;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus0 ();
    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus1 ();

    change_dispenser #(.AMT_W(AMT_W), .EJECT_GAP(2), .CNT_W(CNT_W)) dut0 (
        .clk   (clk),
        .reset (rst0_n),
        .bus   (bus0)
    );

    change_dispenser #(.AMT_W(AMT_W), .EJECT_GAP(0), .CNT_W(CNT_W)) dut1 (
        .clk   (clk),
        .reset (rst1_n),
        .bus   (bus1)
    );

    exp_t q [2][$];
    int   acc [2];
    int   nclk = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
        end
    endtask

    function automatic exp_t ev_ej(input logic [4:0] c, input int off);
        exp_t e;
        e.is_done = 1'b0;
        e.ej      = c;
        e.sf      = '0;
        e.cn      = '0;
        e.off     = off;
        return e;
    endfunction

    function automatic exp_t ev_dn(input int sf, input int cn, input int off);
        exp_t e;
        e.is_done = 1'b1;
        e.ej      = '0;
        e.sf      = AMT_W'(sf);
        e.cn      = CNT_W'(cn);
        e.off     = off;
        return e;
    endfunction

    // Monitor: offsets are counted in falling edges from the one where the request was seen accepted.
    logic [4:0]       s_ej [2];
    logic             s_dn [2];
    logic             s_vl [2];
    logic             s_rd [2];
    logic             s_rs [2];
    logic [AMT_W-1:0] s_sf [2];
    logic [CNT_W-1:0] s_cn [2];

    always @(negedge clk) begin
        exp_t e;
        nclk++;
        s_ej[0] = bus0.eject;     s_ej[1] = bus1.eject;
        s_dn[0] = bus0.done;      s_dn[1] = bus1.done;
        s_vl[0] = bus0.req_valid; s_vl[1] = bus1.req_valid;
        s_rd[0] = bus0.req_ready; s_rd[1] = bus1.req_ready;
        s_rs[0] = rst0_n;         s_rs[1] = rst1_n;
        s_sf[0] = bus0.shortfall; s_sf[1] = bus1.shortfall;
        s_cn[0] = bus0.coins_out; s_cn[1] = bus1.coins_out;
        for (int d = 0; d < 2; d++) begin
            if (s_rs[d] === 1'b1) begin
                if (s_vl[d] && s_rd[d]) acc[d] = nclk;
                if (s_ej[d] != 5'd0 || s_dn[d]) begin
                    if (q[d].size() == 0) begin
                        check($sformatf("d%0d_unexpected_event", d), {26'd0, s_dn[d], s_ej[d]}, 32'd0);
                    end else begin
                        e = q[d].pop_front();
                        check($sformatf("d%0d_kind", d), s_dn[d], e.is_done);
                        check($sformatf("d%0d_eject", d), s_ej[d], e.ej);
                        check($sformatf("d%0d_offset", d), nclk - acc[d], e.off);
                        if (e.is_done) begin
                            check($sformatf("d%0d_shortfall", d), s_sf[d], e.sf);
                            check($sformatf("d%0d_coins_out", d), s_cn[d], e.cn);
                            $display("[TB] d%0d done at +%0d shortfall=%0d coins_out=%0d",
                                     d, nclk - acc[d], s_sf[d], s_cn[d]);
                        end else begin
                            $display("[TB] d%0d eject=%05b at +%0d", d, s_ej[d], nclk - acc[d]);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input bit v, input int amt, input logic [4:0] av);
        if (d == 0) begin
            bus0.req_valid  = v;
            bus0.req_amount = AMT_W'(amt);
            bus0.coin_avail = av;
        end else begin
            bus1.req_valid  = v;
            bus1.req_amount = AMT_W'(amt);
            bus1.coin_avail = av;
        end
    endtask

    task automatic send(input int d, input int amt, input logic [4:0] av, input bit hold);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive(d, 1'b1, amt, av);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if ((d == 0) ? bus0.req_ready : bus1.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("d%0d_accept", d), ok, 1);
        @(posedge clk); #1;
        if (!hold) begin
            if (d == 0) bus0.req_valid = 1'b0;
            else        bus1.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (q[d].size() == 0 && !((d == 0) ? bus0.busy : bus1.busy)) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("d%0d_finish_in_time", d), ok, 1);
    endtask

    task automatic check_reset_outputs(input string pfx, input logic rdy, input logic [4:0] ej,
                                       input logic bsy, input logic dn,
                                       input logic [AMT_W-1:0] sf, input logic [CNT_W-1:0] cn);
        check({pfx, "_req_ready"}, rdy, 1);
        check({pfx, "_eject"}, ej, 0);
        check({pfx, "_busy"}, bsy, 0);
        check({pfx, "_done"}, dn, 0);
        check({pfx, "_shortfall"}, sf, 0);
        check({pfx, "_coins_out"}, cn, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first_acc;
        bit  ok;
        acc[0] = 0;
        acc[1] = 0;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        drive(0, 1'b0, 0, 5'b11111);
        drive(1, 1'b0, 0, 5'b11111);
        #2;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        #20;
        check_reset_outputs("d0_por", bus0.req_ready, bus0.eject, bus0.busy, bus0.done, bus0.shortfall, bus0.coins_out);
        check_reset_outputs("d1_por", bus1.req_ready, bus1.eject, bus1.busy, bus1.done, bus1.shortfall, bus1.coins_out);
        @(posedge clk); #1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        // 65 with everything available: half, dime, nickel
        q[0].push_back(ev_ej(5'b01000, 2));
        q[0].push_back(ev_ej(5'b00010, 6));
        q[0].push_back(ev_ej(5'b00001, 10));
        q[0].push_back(ev_dn(0, 3, 14));
        send(0, 65, 5'b11111, 1'b0);
        wait_idle(0);

        // 30 with quarter and dime only: greedy leaves 5
        q[0].push_back(ev_ej(5'b00100, 2));
        q[0].push_back(ev_dn(5, 1, 6));
        send(0, 30, 5'b00110, 1'b0);
        wait_idle(0);

        // Reset during the gap after the first eject
        q[0].push_back(ev_ej(5'b01000, 2));
        send(0, 65, 5'b11111, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus0.eject != 5'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("d0_first_eject_seen", ok, 1);
        @(posedge clk); #1;
        rst0_n = 1'b0;
        #1;
        check_reset_outputs("d0_midreset", bus0.req_ready, bus0.eject, bus0.busy, bus0.done, bus0.shortfall, bus0.coins_out);
        q[0].delete();
        @(posedge clk); #1;
        rst0_n = 1'b1;

        // Same request after reset behaves as from fresh reset
        q[0].push_back(ev_ej(5'b01000, 2));
        q[0].push_back(ev_ej(5'b00010, 6));
        q[0].push_back(ev_ej(5'b00001, 10));
        q[0].push_back(ev_dn(0, 3, 14));
        send(0, 65, 5'b11111, 1'b0);
        wait_idle(0);

        // Zero amount: straight to done
        q[0].push_back(ev_dn(0, 0, 2));
        send(0, 0, 5'b11111, 1'b0);
        wait_idle(0);

        // 100 with availability dropping mid-request, valid held throughout
        q[0].push_back(ev_ej(5'b01000, 2));
        q[0].push_back(ev_ej(5'b01000, 6));
        q[0].push_back(ev_dn(0, 2, 10));
        q[0].push_back(ev_ej(5'b00010, 2));
        q[0].push_back(ev_dn(0, 1, 6));
        send(0, 100, 5'b11111, 1'b1);
        first_acc = acc[0];
        drive(0, 1'b1, 10, 5'b01111);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus0.eject != 5'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("d0_drop_first_eject_seen", ok, 1);
        #1;
        bus0.coin_avail = 5'b01110;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc[0] != first_acc) begin
                ok = 1'b1;
                break;
            end
        end
        check("d0_held_valid_reaccepted", ok, 1);
        check("d0_held_valid_accept_gap", acc[0] - first_acc, 11);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        wait_idle(0);

        // No-gap instance: dollar then five nickels, 2 left over
        q[1].push_back(ev_ej(5'b10000, 2));
        for (int k = 0; k < 5; k++) q[1].push_back(ev_ej(5'b00001, 4 + 2 * k));
        q[1].push_back(ev_dn(2, 6, 14));
        send(1, 127, 5'b10001, 1'b0);
        wait_idle(1);

        repeat (3) @(negedge clk);
        check("d0_queue_drained", q[0].size(), 0);
        check("d1_queue_drained", q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
